// File: rtl/pbuff_pkg.sv
// Shared defaults and FSM state encoding for the pixel-buffer write arbiter.
package pbuff_pkg;

  localparam int ADDR_W_DEF    = 17;
  localparam int DATA_W_DEF    = 16;
  localparam int BURST_MAX_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_G0   = 2'd1,
    ST_G1   = 2'd2
  } pb_state_e;

endpackage

// File: rtl/pbuff_rr_arb2.sv
// Two-way round-robin pick: on a tie, the requester that did not own the port last wins.
module pbuff_rr_arb2 (
  input  logic r0_valid_i,
  input  logic r1_valid_i,
  input  logic last_grant_i,
  output logic req_o,
  output logic pick_o
);

  always_comb begin
    req_o  = r0_valid_i | r1_valid_i;
    pick_o = 1'b0;
    if (r0_valid_i && r1_valid_i) begin
      pick_o = ~last_grant_i;
    end else if (r1_valid_i) begin
      pick_o = 1'b1;
    end
  end

endmodule

// File: rtl/pbuff_wr_arbiter.sv
// Arbitrates two word-write requesters onto the pixel buffer write port in bounded bursts.
//   state   | meaning
//   ST_IDLE | no owner; one-cycle gap between grants
//   ST_G0   | requester 0 owns the write port
//   ST_G1   | requester 1 owns the write port
module pbuff_wr_arbiter
  import pbuff_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BURST_MAX = BURST_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              r0_valid,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_data,
  output logic              r0_ready,
  input  logic              r1_valid,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_data,
  output logic              r1_ready,
  output logic              pb_wren,
  output logic [ADDR_W-1:0] pb_addr,
  output logic [DATA_W-1:0] pb_data,
  output logic [1:0]        grant,
  output logic              busy
);

  localparam int CNT_W = $clog2(BURST_MAX);
  // The counter never holds BURST_MAX itself; the final transfer is detected one step early.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_MAX - 1);

  pb_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              pb_wren_q;
  logic [ADDR_W-1:0] pb_addr_q;
  logic [DATA_W-1:0] pb_data_q;

  logic              arb_req, arb_pick;
  logic              own_valid, xfer;
  logic [ADDR_W-1:0] xfer_addr;
  logic [DATA_W-1:0] xfer_data;

  pbuff_rr_arb2 u_arb (
    .r0_valid_i  (r0_valid),
    .r1_valid_i  (r1_valid),
    .last_grant_i(last_q),
    .req_o       (arb_req),
    .pick_o      (arb_pick)
  );

  always_comb begin
    r0_ready  = (state_q == ST_G0) && en && !reset;
    r1_ready  = (state_q == ST_G1) && en && !reset;
    own_valid = (state_q == ST_G1) ? r1_valid : r0_valid;
    xfer      = (r0_valid && r0_ready) || (r1_valid && r1_ready);
    xfer_addr = (state_q == ST_G1) ? r1_addr : r0_addr;
    xfer_data = (state_q == ST_G1) ? r1_data : r0_data;
    grant     = {state_q == ST_G1, state_q == ST_G0};
    busy      = (state_q != ST_IDLE);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (arb_req) begin
          state_d = arb_pick ? ST_G1 : ST_G0;
        end
      end
      ST_G0, ST_G1: begin
        if (xfer) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = ST_IDLE;
            last_d  = (state_q == ST_G1);
          end
        end else if (!own_valid) begin
          state_d = ST_IDLE;
          last_d  = (state_q == ST_G1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      last_q    <= 1'b1;
      pb_wren_q <= 1'b0;
      pb_addr_q <= '0;
      pb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      pb_wren_q <= xfer;
      if (xfer) begin
        pb_addr_q <= xfer_addr;
        pb_data_q <= xfer_data;
      end
    end
  end

  assign pb_wren = pb_wren_q;
  assign pb_addr = pb_addr_q;
  assign pb_data = pb_data_q;

endmodule
